// File: rtl/video_write_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// video_write_arbiter_if: host / CPU / clear-control and video RAM write bus
// Rev 1.0
// ==========================================================================
interface video_write_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              host_we;
  logic [ADDR_W-1:0] host_pos;
  logic [7:0]        host_char;
  logic [7:0]        host_color;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_pos;
  logic [7:0]        cpu_char;
  logic [7:0]        cpu_color;
  logic              cpu_ack;
  logic              clear_start;
  logic              clear_busy;
  logic              host_dropped;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_char;
  logic [7:0]        ram_color;

  modport slave (
    input  host_we, host_pos, host_char, host_color,
    input  cpu_req, cpu_pos, cpu_char, cpu_color,
    input  clear_start,
    output cpu_ack, clear_busy, host_dropped,
    output ram_addr, ram_we, ram_char, ram_color
  );

  modport master (
    output host_we, host_pos, host_char, host_color,
    output cpu_req, cpu_pos, cpu_char, cpu_color,
    output clear_start,
    input  cpu_ack, clear_busy, host_dropped,
    input  ram_addr, ram_we, ram_char, ram_color
  );
endinterface
`default_nettype wire

// File: rtl/video_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// video_write_arbiter: owns the video RAM write port; host, CPU and clear
// Rev 1.0
// ==========================================================================
module video_write_arbiter #(
  parameter int                ADDR_W      = 13,
  parameter logic [7:0]        CLEAR_CHAR  = 8'h20,
  parameter logic [7:0]        CLEAR_COLOR = 8'h07,
  parameter logic [ADDR_W-1:0] CLEAR_LAST  = {ADDR_W{1'b1}}
) (
  input wire                   clock,
  input wire                   reset,
  video_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            r_state, w_state_next;
  logic              r_sync1, r_sync2, r_sync3;
  logic [1:0]        r_arm;
  logic              w_armed;
  logic              w_host_edge;
  logic              r_host_pending;
  logic              r_host_dropped;
  logic [ADDR_W-1:0] r_host_pos;
  logic [7:0]        r_host_char;
  logic [7:0]        r_host_color;
  logic              r_last_cpu, w_last_cpu_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt_next;
  logic              r_ram_we, w_ram_we_next;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
  logic [7:0]        r_ram_char, w_ram_char_next;
  logic [7:0]        r_ram_color, w_ram_color_next;
  logic              r_cpu_ack, w_cpu_ack_next;
  logic              r_clear_busy, w_clear_busy_next;
  logic              w_grant_host;
  logic              w_cpu_valid;

  // Edges are ignored until the synchronizer has flushed its reset state.
  assign w_armed     = (r_arm == 2'd3);
  assign w_host_edge = r_sync2 & ~r_sync3 & w_armed;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_arm   <= 2'd0;
    end else begin
      r_sync1 <= bus.host_we;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (!w_armed) r_arm <= r_arm + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_host_pending <= 1'b0;
      r_host_dropped <= 1'b0;
      r_host_pos     <= '0;
      r_host_char    <= 8'h00;
      r_host_color   <= 8'h00;
    end else begin
      if (w_grant_host) r_host_pending <= 1'b0;
      if (w_host_edge) begin
        if (r_host_pending) begin
          r_host_dropped <= 1'b1;
        end else begin
          r_host_pending <= 1'b1;
          r_host_pos     <= bus.host_pos;
          r_host_char    <= bus.host_char;
          r_host_color   <= bus.host_color;
        end
      end
    end
  end

  // The request is still high while its ack is on the bus; it is not a new one yet.
  assign w_cpu_valid = bus.cpu_req & ~r_cpu_ack;

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_last_cpu_next   = r_last_cpu;
    w_ram_we_next     = 1'b0;
    w_ram_addr_next   = r_ram_addr;
    w_ram_char_next   = r_ram_char;
    w_ram_color_next  = r_ram_color;
    w_cpu_ack_next    = 1'b0;
    w_clear_busy_next = 1'b0;
    w_grant_host      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.clear_start) begin
          w_ram_we_next     = 1'b1;
          w_ram_addr_next   = '0;
          w_ram_char_next   = CLEAR_CHAR;
          w_ram_color_next  = CLEAR_COLOR;
          w_clear_busy_next = 1'b1;
          if (CLEAR_LAST != '0) begin
            w_state_next = ST_CLEAR;
            w_cnt_next   = ADDR_W'(1);
          end
        end else if (r_host_pending && (!w_cpu_valid || r_last_cpu)) begin
          w_grant_host     = 1'b1;
          w_ram_we_next    = 1'b1;
          w_ram_addr_next  = r_host_pos;
          w_ram_char_next  = r_host_char;
          w_ram_color_next = r_host_color;
          if (w_cpu_valid) w_last_cpu_next = 1'b0;
        end else if (w_cpu_valid) begin
          w_cpu_ack_next   = 1'b1;
          w_ram_we_next    = 1'b1;
          w_ram_addr_next  = bus.cpu_pos;
          w_ram_char_next  = bus.cpu_char;
          w_ram_color_next = bus.cpu_color;
          if (r_host_pending) w_last_cpu_next = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_ram_we_next     = 1'b1;
        w_ram_addr_next   = r_cnt;
        w_ram_char_next   = CLEAR_CHAR;
        w_ram_color_next  = CLEAR_COLOR;
        w_clear_busy_next = 1'b1;
        if (r_cnt == CLEAR_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + ADDR_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_cpu   <= 1'b1;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_char   <= 8'h00;
      r_ram_color  <= 8'h00;
      r_cpu_ack    <= 1'b0;
      r_clear_busy <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_last_cpu   <= w_last_cpu_next;
      r_ram_we     <= w_ram_we_next;
      r_ram_addr   <= w_ram_addr_next;
      r_ram_char   <= w_ram_char_next;
      r_ram_color  <= w_ram_color_next;
      r_cpu_ack    <= w_cpu_ack_next;
      r_clear_busy <= w_clear_busy_next;
    end
  end

  assign bus.ram_we       = r_ram_we;
  assign bus.ram_addr     = r_ram_addr;
  assign bus.ram_char     = r_ram_char;
  assign bus.ram_color    = r_ram_color;
  assign bus.cpu_ack      = r_cpu_ack;
  assign bus.clear_busy   = r_clear_busy;
  assign bus.host_dropped = r_host_dropped;

endmodule
`default_nettype wire
